// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module      : lcd_pkg
//  Description : HD44780 opcodes, character codes, init command list and the
//                bus-arbiter state encoding shared by the LCD datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'h08;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_RETURN_HOME  = 8'h02;
    localparam logic [7:0] CMD_SET_LINE1    = 8'h80;
    localparam logic [7:0] CMD_SET_LINE2    = 8'hC0;

    localparam logic [7:0] CG_SPACE  = 8'h20;
    localparam logic [7:0] CG_DASH   = 8'h2D;
    localparam logic [7:0] CG_SLASH  = 8'h2F;
    localparam logic [7:0] CG_DIGIT0 = 8'h30;
    localparam logic [7:0] CG_COLON  = 8'h3A;
    localparam logic [7:0] CG_UPPER_A = 8'h41;
    localparam logic [7:0] CG_LOWER_A = 8'h61;

    localparam int INIT_LEN = 6;

    typedef enum logic [1:0] {
        S_PWRUP = 2'd0,
        S_INIT  = 2'd1,
        S_IDLE  = 2'd2,
        S_SLOT  = 2'd3
    } lcd_state_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = CMD_FUNCTION_SET;
            3'd1:    init_cmd = CMD_DISPLAY_OFF;
            3'd2:    init_cmd = CMD_CLEAR;
            3'd3:    init_cmd = CMD_ENTRY_MODE;
            3'd4:    init_cmd = CMD_DISPLAY_ON;
            default: init_cmd = CMD_RETURN_HOME;
        endcase
    endfunction

    // Clear and Return Home need extra execution time inside the controller.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        is_long_cmd = !rs && ((data == CMD_CLEAR) || (data == CMD_RETURN_HOME));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_tick_gen.sv
// ============================================================================
//  Module      : lcd_tick_gen
//  Description : Free-running 0..CNT1MS-1 counter producing a one-clk 1 ms tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_tick_gen #(
    parameter int CNT1MS = 100_000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick1ms
);

    localparam int CW = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT1MS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            tick1ms <= 1'b0;
        end else begin
            tick1ms <= (cnt == CNT_MAX);
            cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
// ============================================================================
//  Module      : lcd_bus_arbiter
//  Description : Runs HD44780 init, then shares the LCD bus between two byte
//                requesters with round-robin plus burst lock; 1 ms paced writes.
//                Optional LCD_PWRUP_WAIT_EN adds a PWRUP_MS wait before init.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int CNT1MS        = 100_000,
    parameter int PWRUP_MS      = 20,
    parameter int LONG_EXTRA_MS = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_lock,
    output logic [1:0]  req_ready,
    output logic        init_done,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    localparam int PH_MAX = (PWRUP_MS > 3 + LONG_EXTRA_MS) ? PWRUP_MS : 3 + LONG_EXTRA_MS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PH_END_SHORT = PH_W'(3);
    localparam logic [PH_W-1:0] PH_END_LONG  = PH_W'(3 + LONG_EXTRA_MS);
`ifdef LCD_PWRUP_WAIT_EN
    localparam lcd_state_t RESET_STATE = S_PWRUP;
`else
    localparam lcd_state_t RESET_STATE = S_INIT;
`endif

    logic            tick1ms;
    lcd_state_t      state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt, ph_inc;
    logic [2:0]      init_idx, init_idx_nxt;
    logic            init_done_nxt;
    logic            rr_last, rr_last_nxt;
    logic            owner_vld, owner_vld_nxt;
    logic            owner_id, owner_id_nxt;
    logic            slot_long, slot_long_nxt;
    logic            lcd_e_nxt, lcd_rs_nxt;
    logic [7:0]      lcd_data_nxt;
    logic            grant, gid;

    lcd_tick_gen #(
        .CNT1MS (CNT1MS)
    ) u_tick (
        .clk     (clk),
        .resetn  (resetn),
        .tick1ms (tick1ms)
    );

    assign lcd_rw = 1'b0;
    assign ph_inc = ph + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= RESET_STATE;
            ph        <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            rr_last   <= 1'b1;
            owner_vld <= 1'b0;
            owner_id  <= 1'b0;
            slot_long <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            ph        <= ph_nxt;
            init_idx  <= init_idx_nxt;
            init_done <= init_done_nxt;
            rr_last   <= rr_last_nxt;
            owner_vld <= owner_vld_nxt;
            owner_id  <= owner_id_nxt;
            slot_long <= slot_long_nxt;
            lcd_e     <= lcd_e_nxt;
            lcd_rs    <= lcd_rs_nxt;
            lcd_data  <= lcd_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ph_nxt        = ph;
        init_idx_nxt  = init_idx;
        init_done_nxt = init_done;
        rr_last_nxt   = rr_last;
        owner_vld_nxt = owner_vld;
        owner_id_nxt  = owner_id;
        slot_long_nxt = slot_long;
        lcd_rs_nxt    = lcd_rs;
        lcd_data_nxt  = lcd_data;
        req_ready     = 2'b00;
        grant         = 1'b0;
        gid           = 1'b0;

        case (state)
            S_PWRUP: begin
`ifdef LCD_PWRUP_WAIT_EN
                if (tick1ms) begin
                    if (ph == PH_W'(PWRUP_MS - 1)) begin
                        ph_nxt    = '0;
                        state_nxt = S_INIT;
                    end else begin
                        ph_nxt = ph_inc;
                    end
                end
`else
                state_nxt = S_INIT;
`endif
            end

            S_INIT: begin
                lcd_rs_nxt    = 1'b0;
                lcd_data_nxt  = init_cmd(init_idx);
                slot_long_nxt = is_long_cmd(1'b0, init_cmd(init_idx));
                ph_nxt        = '0;
                state_nxt     = S_SLOT;
            end

            S_IDLE: begin
                // A held lock blocks the other requester even when it is valid.
                if (owner_vld && req_lock[owner_id]) begin
                    grant = req_valid[owner_id];
                    gid   = owner_id;
                end else begin
                    owner_vld_nxt = 1'b0;
                    if (req_valid[~rr_last]) begin
                        grant = 1'b1;
                        gid   = ~rr_last;
                    end else if (req_valid[rr_last]) begin
                        grant = 1'b1;
                        gid   = rr_last;
                    end
                end

                if (grant) begin
                    req_ready     = gid ? 2'b10 : 2'b01;
                    lcd_rs_nxt    = req_rs[gid];
                    lcd_data_nxt  = gid ? req_data[15:8] : req_data[7:0];
                    slot_long_nxt = is_long_cmd(req_rs[gid], gid ? req_data[15:8] : req_data[7:0]);
                    rr_last_nxt   = gid;
                    if (req_lock[gid]) begin
                        owner_vld_nxt = 1'b1;
                        owner_id_nxt  = gid;
                    end
                    ph_nxt    = '0;
                    state_nxt = S_SLOT;
                end
            end

            S_SLOT: begin
                if (tick1ms) begin
                    if (ph_inc == (slot_long ? PH_END_LONG : PH_END_SHORT)) begin
                        ph_nxt = '0;
                        if (init_done) begin
                            state_nxt = S_IDLE;
                        end else if (init_idx == 3'(INIT_LEN - 1)) begin
                            init_done_nxt = 1'b1;
                            state_nxt     = S_IDLE;
                        end else begin
                            init_idx_nxt = init_idx + 1'b1;
                            state_nxt    = S_INIT;
                        end
                    end else begin
                        ph_nxt = ph_inc;
                    end
                end
            end

            default: state_nxt = RESET_STATE;
        endcase
    end

    // E is registered from the next phase so it is high exactly while ph==1.
    assign lcd_e_nxt = (state_nxt == S_SLOT) && (ph_nxt == PH_W'(1));

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
// ============================================================================
//  Module      : tb_lcd_bus_arbiter
//  Description : Directed self-checking bench for lcd_bus_arbiter (CNT1MS=10).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_rs = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_lock = 2'b00;
    logic [1:0]  req_ready;
    logic        init_done;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit ready_in_init = 1'b0;

    lcd_bus_arbiter #(
        .CNT1MS        (10),
        .PWRUP_MS      (20),
        .LONG_EXTRA_MS (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (resetn && !init_done && req_ready != 2'b00) ready_in_init <= 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_e(input logic want, input int budget, output int t);
        int n = 0;
        while (lcd_e !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (lcd_e !== want) check_val("timeout_lcd_e", 32'(lcd_e), 32'(want));
        t = cyc;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 2'b00) check_val("timeout_ready", 32'(req_ready), 32'h1);
    endtask

    initial begin
        logic [7:0] exp_cmd [6];
        int t, t_rise, t_fall, prev_rise, r0, delay, n;
        int rises, bad, n1;
        bit order_ok, got0, done;
        logic prev_e;

        exp_cmd = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h02};
        prev_rise = 0;

        repeat (3) @(negedge clk);
        check_val("rst_lcd_e", 32'(lcd_e), 32'h0);
        check_val("rst_lcd_rs", 32'(lcd_rs), 32'h0);
        check_val("rst_lcd_data", 32'(lcd_data), 32'h00);
        check_val("rst_req_ready", 32'(req_ready), 32'h0);
        check_val("rst_init_done", 32'(init_done), 32'h0);
        check_val("lcd_rw", 32'(lcd_rw), 32'h0);

        // Init sequence: commands, E width, slot pacing, init_done latency.
        resetn = 1'b1;
        r0 = cyc;
        for (int i = 0; i < 6; i++) begin
            wait_e(1'b0, 100, t);
            wait_e(1'b1, 400, t_rise);
            if (i == 0) begin
                delay = t_rise - r0;
`ifdef LCD_PWRUP_WAIT_EN
                check_val("pwrup_delay_ge_200", 32'(delay >= 200), 32'h1);
`else
                check_val("first_e_delay", 32'(delay), 32'd11);
`endif
            end
            check_val("init_cmd", 32'(lcd_data), 32'(exp_cmd[i]));
            check_val("init_rs", 32'(lcd_rs), 32'h0);
            check_val("init_done_low", 32'(init_done), 32'h0);
            wait_e(1'b0, 50, t_fall);
            check_val("init_e_width", 32'(t_fall - t_rise), 32'd10);
            if (i > 0)
                check_val("init_period", 32'(t_rise - prev_rise),
                          (exp_cmd[i-1] == 8'h01) ? 32'd70 : 32'd30);
            prev_rise = t_rise;
        end
        n = 0;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("init_done_latency", 32'(cyc - prev_rise), 32'd60);
        check_val("ready_during_init", 32'(ready_in_init), 32'h0);

        // Round-robin alternation with both requesters valid, no lock.
        @(negedge clk);
        req_rs    = 2'b11;
        req_data  = {8'h61, 8'h41};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_e(1'b0, 100, t);
            wait_e(1'b1, 100, t);
            check_val("rr_data", 32'(lcd_data), (k % 2 == 0) ? 32'h41 : 32'h61);
        end
        req_valid = 2'b00;
        repeat (40) @(negedge clk);

        // Single req0 data byte.
        req_rs    = 2'b01;
        req_data  = {8'h00, 8'h32};
        req_valid = 2'b01;
        wait_ready(100);
        check_val("single_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        check_val("ready_one_clk", 32'(req_ready), 32'h0);
        check_val("single_rs", 32'(lcd_rs), 32'h1);
        check_val("single_data", 32'(lcd_data), 32'h32);
        rises = 0;
        bad = 0;
        prev_e = lcd_e;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (lcd_e && !prev_e) rises++;
            if (lcd_data != 8'h32 || lcd_rs != 1'b1) bad++;
            prev_e = lcd_e;
        end
        check_val("single_e_pulses", 32'(rises), 32'd1);
        check_val("single_stable", 32'(bad), 32'd0);

        // req1 locks the bus for a 17-byte line burst while req0 waits.
        req_rs    = 2'b01;
        req_data  = {8'hC0, 8'h30};
        req_lock  = 2'b10;
        req_valid = 2'b11;
        n1 = 0;
        bad = 0;
        order_ok = 1'b1;
        got0 = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (req_ready == 2'b10) begin
                @(negedge clk);
                if (lcd_data != ((n1 == 0) ? 8'hC0 : 8'(8'h41 + n1 - 1))) bad++;
                n1++;
                if (n1 == 17) begin
                    req_lock     = 2'b00;
                    req_valid[1] = 1'b0;
                end else begin
                    req_rs[1]        = 1'b1;
                    req_data[15:8]   = 8'(8'h41 + n1 - 1);
                end
            end else if (req_ready == 2'b01) begin
                if (n1 < 17) order_ok = 1'b0;
                else got0 = 1'b1;
                done = 1'b1;
                @(negedge clk);
                req_valid[0] = 1'b0;
            end
        end
        check_val("lock_req1_grants", 32'(n1), 32'd17);
        check_val("lock_order", 32'(order_ok), 32'h1);
        check_val("lock_burst_data_errs", 32'(bad), 32'd0);
        check_val("req0_after_unlock", 32'(got0), 32'h1);
        check_val("req0_after_unlock_data", 32'(lcd_data), 32'h30);
        repeat (40) @(negedge clk);

        // Reset pulse while E is high restarts init.
        req_rs    = 2'b01;
        req_data  = {8'h00, 8'h55};
        req_valid = 2'b01;
        wait_ready(100);
        @(negedge clk);
        req_valid = 2'b00;
        wait_e(1'b1, 100, t);
        resetn = 1'b0;
        #1;
        check_val("reset_e_async", 32'(lcd_e), 32'h0);
        check_val("reset_init_done", 32'(init_done), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        r0 = cyc;
        wait_e(1'b1, 400, t);
        delay = t - r0;
`ifdef LCD_PWRUP_WAIT_EN
        check_val("rerun_pwrup_ge_200", 32'(delay >= 200), 32'h1);
`else
        check_val("rerun_first_e_delay", 32'(delay), 32'd11);
`endif
        check_val("rerun_first_cmd", 32'(lcd_data), 32'h38);
        check_val("rerun_init_done", 32'(init_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the single HD44780 16×2 LCD bus and shares it between two byte-level requesters: req0, the date/time line renderer, and req1, the settings/menu overlay.
- Runs the power-up init command sequence itself.
- Paces every bus write with a 1 ms tick.
- Lets a requester lock the bus for a full line burst: address command plus 16 characters.
- Sits between the clock/menu renderers and the LCD pins at the top level.

Parameters:
- CNT1MS, 100_000: clk cycles per 1 ms tick (100 MHz).
- PWRUP_MS, 20: power-up wait in ms, used only with LCD_PWRUP_WAIT_EN.
- LONG_EXTRA_MS, 4: extra hold ticks after Clear (0x01) or Return Home (0x02).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester byte pending.
- req_rs  in  2  per-requester RS (0 = command, 1 = data).
- req_data  in  16  per-requester byte; [7:0] = req0, [15:8] = req1.
- req_lock  in  2  requester holds the bus across successive bytes.
- req_ready  out  2  one-clk accept pulse, one-hot.
- init_done  out  1  init sequence finished; requests are serviced only after this.
- lcd_e  out  1  LCD enable.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_data=0x00, req_ready=0, init_done=0. State=S_PWRUP when LCD_PWRUP_WAIT_EN is defined, else S_INIT. Init index=0, rr_last=1 (req0 wins first), owner=none.
- Tick: free-running counter 0..CNT1MS-1. tick1ms is a one-clk pulse on wrap; the counter restarts from 0 on reset.
- S_PWRUP: count PWRUP_MS ticks, then go to S_INIT.
- S_INIT: issue the 6 init commands 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02 in order through the write slot, RS=0. The write slot (S_SLOT) returns to S_INIT after each one.
  - After the 6th slot completes: init_done=1 (sticky until reset), go to S_IDLE.
  - req_ready stays 0 throughout.
- S_IDLE grant rules:
  - If owner is set and req_lock[owner]=1: only the owner may be granted. The other requester waits even if valid.
  - If owner is set and req_lock[owner]=0: clear owner, then apply round-robin.
  - Round-robin: grant the requester that is not rr_last if it is valid, else the other if valid.
  - On grant g: req_ready[g]=1 for exactly one clk; latch rs/data; rr_last=g; owner=g if req_lock[g]=1; go to S_SLOT.
- S_SLOT: the phase counter ph starts at 0.
  - lcd_rs/lcd_data are registered on the grant edge and held stable for the whole slot.
  - ph advances only on tick1ms. A tick coinciding with the grant cycle is ignored.
  - lcd_e=1 exactly while ph==1, so the E pulse is 1 ms wide and data setup is at least 1 clk.
  - Slot ends on the tick where ph reaches 3 for a normal slot, or 3+LONG_EXTRA_MS when rs=0 and data∈{0x01,0x02}.
  - At slot end, return to S_INIT or S_IDLE.
- Simultaneous events:
  - Both requesters valid with no lock: alternate grants.
  - req_valid dropped mid-slot: no effect; the latched byte completes.
  - req_lock dropped mid-slot: takes effect at the next S_IDLE.
- Reset mid-slot: lcd_e drops to 0 asynchronously and the full init sequence reruns.
- Valid data is sampled only in the grant cycle.

Optional Feature:
- LCD_PWRUP_WAIT_EN.
  - Defined: S_PWRUP waits PWRUP_MS ticks after reset before the first init command (required for real hardware).
  - Undefined: S_PWRUP is removed; the init command 0x38 is latched on the first clk after reset release (fast simulation).

Decomposition:
- Shared package lcd_pkg holds:
  - CMD_* opcodes: FUNCTION_SET 0x38, DISPLAY_OFF 0x08, CLEAR 0x01, ENTRY_MODE 0x06, DISPLAY_ON 0x0C, RETURN_HOME 0x02, SET_LINE1 0x80, SET_LINE2 0xC0.
  - CG_* character codes.
  - The init command list.
  - The state encoding.
- One sub-module: lcd_tick_gen (CNT1MS counter producing tick1ms), reused by the renderers.

Test Plan (CNT1MS=10, LCD_PWRUP_WAIT_EN undefined unless stated):
- Reset release, no requests:
  - lcd_data sequence 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02 with one E pulse each (10 clk wide).
  - 0x01 and 0x02 slots last 7 ticks, the others 3.
  - init_done rises after the 0x02 slot; req_ready stays 0 throughout.
- After init, req0 alone sends rs=1, data=0x32: req_ready=2'b01 for 1 clk; lcd_rs=1, lcd_data=0x32 stable for the slot; a single E pulse.
- Both valid continuously, no lock: grants go req0, req1, req0, req1, checked through lcd_data alternating 0x41/0x61.
- req1 asserts lock and sends 0xC0 plus 16 bytes while req0 stays valid: 17 consecutive req1 grants; req0 is first granted after req1 drops lock.
- resetn pulsed low mid-slot while lcd_e=1: lcd_e=0 immediately; after release the init sequence restarts at 0x38 and init_done=0.
- LCD_PWRUP_WAIT_EN defined, PWRUP_MS=20: the first E pulse starts no earlier than 20 ticks (200 clk) after reset release.
